// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/arith/shift ops in 1 cycle, iterative MUL/DIVU/REMU in WIDTH+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
module alu_mc #(
  parameter int WIDTH         = 32,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011, OP_SLTU = 4'b0100, OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111, OP_SLL  = 4'b1000, OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010, OP_NOR  = 4'b1100, OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_DIVU = 4'b1110, OP_REMU = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             accept, is_md, last;
  logic [WIDTH-1:0] sum, diff, sc_res, md_res;
  logic             sc_ovf;
  logic [WIDTH-1:0] it_acc, it_x, it_y;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic [SW-1:0]    shamt;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign is_md     = ENABLE_MULDIV && (aluop == OP_MUL || aluop == OP_DIVU || aluop == OP_REMU);
  assign last      = (cnt_q == CW'(1));
  assign shamt     = b[SW-1:0];
  assign sum       = a + b;
  assign diff      = a - b;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (aluop)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_SRA:  sc_res = $signed(a) >>> shamt;
      default: sc_res = '0;
    endcase
  end

  // One iteration: MUL shift-add (x=multiplicand, y=multiplier); restoring
  // division shifts the dividend out of x while quotient bits shift into x.
  always_comb begin
    it_acc  = acc_q;
    it_x    = x_q;
    it_y    = y_q;
    rem_sh  = {acc_q, x_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, y_q};
    if (op_q == OP_MUL) begin
      if (y_q[0]) it_acc = acc_q + x_q;
      it_x = x_q << 1;
      it_y = y_q >> 1;
    end else begin
      it_x = {x_q[WIDTH-2:0], 1'b0};
      if (!rem_sub[WIDTH]) begin
        it_acc  = rem_sub[WIDTH-1:0];
        it_x[0] = 1'b1;
      end else begin
        it_acc = rem_sh[WIDTH-1:0];
      end
    end
    md_res = (op_q == OP_DIVU) ? it_x : it_acc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_md ? BUSY : DONE;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= aluop;
          if (is_md) begin
            cnt_q <= CW'(WIDTH);
            acc_q <= '0;
            x_q   <= a;
            y_q   <= b;
          end else begin
            result <= sc_res;
            zero   <= (sc_res == '0);
            ovf    <= sc_ovf;
          end
        end
        BUSY: begin
          acc_q <= it_acc;
          x_q   <= it_x;
          y_q   <= it_y;
          cnt_q <= cnt_q - CW'(1);
          if (last) begin
            result <= md_res;
            zero   <= (md_res == '0);
            ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit instance with MUL/DIV and a 16-bit instance without,
// checked against directed values and an arithmetic reference model.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a, b;
  logic [3:0]  aluop;
  logic        iv1, ir1, ov1, or1, z1, f1;
  logic [31:0] r1;
  logic        iv2, ir2, ov2, or2, z2, f2;
  logic [15:0] r2;
  int tests = 0;
  int fails = 0;

  alu_mc #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .aluop(aluop),
    .out_valid(ov1), .out_ready(or1), .result(r1), .zero(z1), .ovf(f1));

  alu_mc #(.WIDTH(16), .ENABLE_MULDIV(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a[15:0]), .b(b[15:0]),
    .aluop(aluop), .out_valid(ov2), .out_ready(or2), .result(r2), .zero(z2), .ovf(f2));

  // Reference: {ovf, result} from plain integer arithmetic on w-bit values.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] xa, xb,
                                          input int w, input bit md);
    longint mask, ua, ub, sa, sb, r, full, lim;
    int sh;
    bit ov;
    mask = (longint'(1) << w) - longint'(1);
    lim  = longint'(1) << (w - 1);
    ua = longint'({32'h0, xa}) & mask;
    ub = longint'({32'h0, xb}) & mask;
    sa = (ua >= lim) ? ua - (longint'(1) << w) : ua;
    sb = (ub >= lim) ? ub - (longint'(1) << w) : ub;
    sh = int'(ub % longint'(w));
    r = 0;
    ov = 1'b0;
    case (op)
      4'd0:  r = ua & ub;
      4'd1:  r = ua | ub;
      4'd3:  r = ua ^ ub;
      4'd12: r = ~(ua | ub);
      4'd2:  begin full = sa + sb; r = ua + ub; ov = (full >= lim) || (full < -lim); end
      4'd6:  begin full = sa - sb; r = ua - ub; ov = (full >= lim) || (full < -lim); end
      4'd7:  r = longint'(sa < sb);
      4'd4:  r = longint'(ua < ub);
      4'd8:  r = ua << sh;
      4'd9:  r = ua >> sh;
      4'd10: r = sa >>> sh;
      4'd13: if (md) r = ua * ub;
      4'd14: if (md) r = (ub == 0) ? mask : ua / ub;
      4'd15: if (md) r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    r = r & mask;
    return {ov, r[31:0]};
  endfunction

  // Starts and ends just after a falling edge; performs one full handshake on either DUT.
  task automatic run_op(input bit d2, input logic [3:0] op, input logic [31:0] va, vb,
                        output logic [31:0] res, output logic z, output logic ovf, output int lat);
    int n;
    n = 0;
    while (!(d2 ? ir2 : ir1) && n < 100) begin @(negedge clk); n++; end
    aluop = op; a = va; b = vb;
    if (d2) iv2 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv2 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!(d2 ? ov2 : ov1) && lat < 100);
    res = d2 ? {16'h0, r2} : r1;
    z   = d2 ? z2 : z1;
    ovf = d2 ? f2 : f1;
    if (d2) or2 = 1'b1; else or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0; or2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    iv1 = 0; iv2 = 0; or1 = 0; or2 = 0; a = 0; b = 0; aluop = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({ir1, ov1, r1, z1, f1} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset32 got ir=%b ov=%b res=%h z=%b ovf=%b want 1 0 0 0 0", ir1, ov1, r1, z1, f1);
    end
    tests++;
    if ({ir2, ov2, r2, z2, f2} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset16 got ir=%b ov=%b res=%h z=%b ovf=%b want 1 0 0 0 0", ir2, ov2, r2, z2, f2);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  ops [17] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd12, 4'd7, 4'd4, 4'd8, 4'd9, 4'd10, 4'd5,
                              4'd14, 4'd15, 4'd14, 4'd15, 4'd13};
    logic [31:0] as  [17] = '{32'h7FFFFFFF, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                              32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                              32'hF0F0F0F0, 32'd100, 32'd100, 32'd9, 32'd9, 32'hFFFFFFFF};
    logic [31:0] bs  [17] = '{32'd1, 32'd5, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC,
                              32'hC, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF};
    logic [31:0] ex  [17] = '{32'h80000000, 32'h0, 32'h0, 32'hF0F0F0FC, 32'hF0F0F0FC, 32'h0F0F0F03,
                              32'h1, 32'h0, 32'h0F0F0000, 32'h000F0F0F, 32'hFFFF0F0F, 32'h0,
                              32'd14, 32'd2, 32'hFFFFFFFF, 32'd9, 32'h1};
    logic [31:0] res;
    logic z, ovf, eovf;
    int lat, elat;
    for (int i = 0; i < 17; i++) begin
      run_op(1'b0, ops[i], as[i], bs[i], res, z, ovf, lat);
      eovf = (i == 0);
      elat = (ops[i] >= 4'd13) ? 33 : 1;
      tests++;
      if (res !== ex[i] || z !== (ex[i] == 32'h0) || ovf !== eovf || lat != elat) begin
        fails++;
        $display("FAIL directed op=%h a=%h b=%h got res=%h z=%b ovf=%b lat=%0d want res=%h z=%b ovf=%b lat=%0d",
                 ops[i], as[i], bs[i], res, z, ovf, lat, ex[i], ex[i] == 32'h0, eovf, elat);
      end
    end
  endtask

  task automatic test_mul_busy();
    int lat;
    tests++;
    if (ir1 !== 1'b1) begin fails++; $display("FAIL mul_start in_ready got %b want 1", ir1); end
    aluop = 4'hD; a = 32'h00012345; b = 32'h00000100; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (!ov1) begin
        tests++;
        if (ir1 !== 1'b0) begin fails++; $display("FAIL busy_in_ready cyc=%0d got %b want 0", lat, ir1); end
        iv1 = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom; aluop = 4'($urandom_range(0, 15));
      end
    end while (!ov1 && lat < 100);
    iv1 = 1'b0;
    tests++;
    if (lat != 33 || r1 !== 32'h01234500 || z1 !== 1'b0 || f1 !== 1'b0) begin
      fails++; $display("FAIL mul got lat=%0d res=%h z=%b ovf=%b want lat=33 res=01234500 z=0 ovf=0", lat, r1, z1, f1);
    end
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    @(negedge clk);
    tests++;
    if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
      fails++; $display("FAIL mul_after got ov=%b ir=%b want ov=0 ir=1", ov1, ir1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] va, vb, held, res;
    logic [32:0] e;
    logic z, ovf;
    int lat;
    va = $urandom; vb = $urandom;
    e = ref_alu(4'd2, va, vb, 32, 1'b1);
    aluop = 4'd2; a = va; b = vb; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; a = ~va; b = ~vb;
    @(negedge clk);
    held = r1;
    tests++;
    if (ov1 !== 1'b1 || held !== e[31:0]) begin
      fails++; $display("FAIL bp_first got ov=%b res=%h want ov=1 res=%h", ov1, held, e[31:0]);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (ov1 !== 1'b1 || ir1 !== 1'b0 || r1 !== held || f1 !== e[32]) begin
        fails++; $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b res=%h ovf=%b want 1 0 %h %b", i, ov1, ir1, r1, f1, held, e[32]);
      end
    end
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    @(negedge clk);
    tests++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0) begin
      fails++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", ir1, ov1);
    end
    for (int i = 0; i < 4; i++) begin
      va = $urandom; vb = $urandom;
      e = ref_alu(4'd6, va, vb, 32, 1'b1);
      run_op(1'b0, 4'd6, va, vb, res, z, ovf, lat);
      tests++;
      if (res !== e[31:0] || ovf !== e[32] || lat != 1) begin
        fails++; $display("FAIL b2b i=%0d got res=%h ovf=%b lat=%0d want res=%h ovf=%b lat=1", i, res, ovf, lat, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_random(input bit d2, input int n);
    logic [3:0]  op;
    logic [31:0] va, vb, res, er;
    logic [32:0] e;
    logic z, ovf;
    int lat, elat, w;
    w = d2 ? 16 : 32;
    for (int i = 0; i < n; i++) begin
      op = (i < 3 && d2) ? 4'(13 + i) : 4'($urandom_range(0, 15));
      va = $urandom;
      vb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      e  = ref_alu(op, va, vb, w, !d2);
      er = e[31:0];
      elat = (!d2 && op >= 4'd13) ? 33 : 1;
      run_op(d2, op, va, vb, res, z, ovf, lat);
      tests++;
      if (res !== er || z !== (er == 32'h0) || ovf !== e[32] || lat != elat) begin
        fails++;
        $display("FAIL random w=%0d op=%h a=%h b=%h got res=%h z=%b ovf=%b lat=%0d want res=%h z=%b ovf=%b lat=%0d",
                 w, op, va, vb, res, z, ovf, lat, er, er == 32'h0, e[32], elat);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] res;
    logic z, ovf, seen;
    int lat;
    aluop = 4'hD; a = 32'h00012345; b = 32'h00000100; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (ov1 !== 1'b0 || ir1 !== 1'b1 || r1 !== 32'h0) begin
      fails++; $display("FAIL rst_busy got ov=%b ir=%b res=%h want ov=0 ir=1 res=0", ov1, ir1, r1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov1 !== 1'b0 || ir1 !== 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL rst_stale got stale activity=%b want 0", seen); end
    run_op(1'b0, 4'd2, 32'd2, 32'd3, res, z, ovf, lat);
    tests++;
    if (res !== 32'd5 || z !== 1'b0 || ovf !== 1'b0 || lat != 1) begin
      fails++; $display("FAIL rst_add got res=%h z=%b ovf=%b lat=%0d want 5 0 0 1", res, z, ovf, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul_busy();
    test_backpressure();
    test_random(1'b0, 80);
    test_reset_mid_busy();
    test_random(1'b1, 40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
